// File: rtl/tick_sched_if.sv
// tick_sched_if
//  Bundles the config handshake, run control and status signals of
//  tick_sched. clk and rst_n are not part of the bundle.
//
//  Ports (signals):
//   cfg_valid    config offer                      (master -> slave)
//   cfg_ready    config accepted when both high    (slave -> master)
//   cfg_period   period in base ticks, 0 means 1   (master -> slave)
//   cfg_oneshot  1 = one-shot, 0 = periodic        (master -> slave)
//   start, stop  level-sampled run control         (master -> slave)
//   tick         1-cycle pulse at each period end  (slave -> master)
//   done         1-cycle pulse at one-shot end     (slave -> master)
//   busy         high while running                (slave -> master)
//   tick_cnt     tick counter, only with TICK_SCHED_CNT_EN defined
interface tick_sched_if #(
  parameter int PERIOD_W = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_oneshot;
  logic                start;
  logic                stop;
  logic                tick;
  logic                done;
  logic                busy;
`ifdef TICK_SCHED_CNT_EN
  logic [15:0]         tick_cnt;

  modport master (
    output cfg_valid, cfg_period, cfg_oneshot, start, stop,
    input  cfg_ready, tick, done, busy, tick_cnt
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_oneshot, start, stop,
    output cfg_ready, tick, done, busy, tick_cnt
  );
`else
  modport master (
    output cfg_valid, cfg_period, cfg_oneshot, start, stop,
    input  cfg_ready, tick, done, busy
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_oneshot, start, stop,
    output cfg_ready, tick, done, busy
  );
`endif
endinterface

// File: rtl/tick_sched.sv
// tick_sched
//  Programmable tick scheduler. A prescaler divides clk by DIV = F_0/F_1
//  into a base tick; a period counter counts base ticks and emits a
//  registered one-cycle tick at each period end. Periodic or one-shot.
//
//  Ports:
//   clk    system clock
//   rst_n  async active-low reset
//   bus    tick_sched_if.slave (cfg handshake, start/stop, tick/done/busy)
//
//  Optional build macro TICK_SCHED_CNT_EN: adds bus.tick_cnt, a 16-bit
//  wrapping count of tick pulses, cleared on each accepted config.
//
//  state | meaning
//  IDLE  | waiting; cfg_ready=1, config may be loaded, start begins a run
//  RUN   | prescaler and period counter running, ticks emitted
module tick_sched #(
  parameter int F_0      = 50_000_000,
  parameter int F_1      = 1000,
  parameter int PERIOD_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  tick_sched_if.slave bus
);

  localparam int DIV   = F_0 / F_1;
  localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_nxt;
  logic [PSC_W-1:0]    psc_q;
  logic [PERIOD_W-1:0] pcnt_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_m1;
  logic                oneshot_q;
  logic                cfg_loaded_q;
  logic                tick_q;
  logic                done_q;

  logic                base_tick;
  logic                term;
  logic                cfg_hs;
  logic                tick_nxt;
  logic                done_nxt;

  assign period_m1 = period_q - 1'b1;
  assign base_tick = (psc_q == PSC_MAX);
  assign term      = base_tick && (pcnt_q == period_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cfg_hs    = 1'b0;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_hs = bus.cfg_valid;
        // stop wins over start; start before any config is ignored
        if (bus.start && !bus.stop && cfg_loaded_q) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else begin
          // done is already out; leave RUN one cycle after the final tick
          if (done_q) begin
            state_nxt = IDLE;
          end
          if (term) begin
            tick_nxt = 1'b1;
            done_nxt = oneshot_q;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q        <= '0;
      pcnt_q       <= '0;
      period_q     <= PERIOD_W'(1);
      oneshot_q    <= 1'b0;
      cfg_loaded_q <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      tick_q <= tick_nxt;
      done_q <= done_nxt;
      if (cfg_hs) begin
        period_q     <= (bus.cfg_period == '0) ? PERIOD_W'(1) : bus.cfg_period;
        oneshot_q    <= bus.cfg_oneshot;
        cfg_loaded_q <= 1'b1;
      end
      // counters sit at 0 outside RUN, so entering RUN starts from 0
      if (state_q != RUN) begin
        psc_q  <= '0;
        pcnt_q <= '0;
      end else begin
        psc_q <= base_tick ? '0 : psc_q + 1'b1;
        if (base_tick) begin
          pcnt_q <= term ? '0 : pcnt_q + 1'b1;
        end
      end
    end
  end

`ifdef TICK_SCHED_CNT_EN
  logic [15:0] tick_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (cfg_hs) begin
      tick_cnt_q <= '0;
    end else if (tick_nxt) begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  assign bus.tick_cnt = tick_cnt_q;
`endif

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;

endmodule
